// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 widths, dump sync byte and dump state encoding
package sap1_pkg;
   localparam int         SAP1_AW        = 4;
   localparam int         SAP1_DW        = 8;
   localparam int         SAP1_DEPTH     = 16;
   localparam logic [7:0] SAP1_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_READ  = 3'd4,
      ST_LATCH = 3'd5,
      ST_DONE  = 3'd6
   } state_t;
endpackage

// File: rtl/sap1_memory_dump_tx_if.sv
// rtl/sap1_memory_dump_tx_if.sv - program RAM read port used by the memory dump block
interface sap1_memory_dump_tx_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic [AW-1:0] mem_a;
   logic          mem_n_ce;
   logic [DW-1:0] mem_d;

   modport master (output mem_a, output mem_n_ce, input mem_d);
   modport slave  (input mem_a, input mem_n_ce, output mem_d);
endinterface

// File: rtl/sap1_memory_dump_tx_uart_tx_serializer.sv
// rtl/sap1_memory_dump_tx_uart_tx_serializer.sv - 8N1 LSB-first UART frame serializer
// load starts a frame on the next cycle; frame_done marks the last cycle of the stop bit.
module sap1_uart_tx_serializer
   import sap1_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)(
   input  logic       clk,
   input  logic       n_clr,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       frame_done
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   state_t        phase, phase_next;
   logic [CW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          baud_last;

   assign baud_last = (baud == BAUD_LAST);

   always_comb begin
      phase_next = phase;
      tx         = 1'b1;
      frame_done = 1'b0;
      case (phase)
         ST_START: begin
            tx = 1'b0;
            if (baud_last) phase_next = ST_DATA;
         end
         ST_DATA: begin
            tx = shreg[0];
            if (baud_last && bit_cnt == 3'd7) phase_next = ST_STOP;
         end
         ST_STOP: begin
            if (baud_last) begin
               frame_done = 1'b1;
               phase_next = ST_IDLE;
            end
         end
         default: phase_next = phase;
      endcase
      if (load) phase_next = ST_START;
   end

   // Phase changes only happen on baud_last or load, so both clear the baud counter.
   always_ff @(posedge clk) begin
      if (!n_clr) begin
         phase   <= ST_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         phase <= phase_next;
         if (load || phase == ST_IDLE || baud_last) baud <= '0;
         else                                       baud <= baud + 1'b1;
         if (load) begin
            shreg   <= byte_in;
            bit_cnt <= '0;
         end else if (phase == ST_DATA && baud_last) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end
endmodule

// File: rtl/sap1_memory_dump_tx.sv
// rtl/sap1_memory_dump_tx.sv - dumps the SAP-1 program RAM over UART: sync byte, then words 0..DEPTH-1
// START/DATA/STOP timing is run by the serializer; the top waits in ST_START until frame_done.
module sap1_memory_dump_tx
   import sap1_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         DEPTH        = SAP1_DEPTH,
   parameter int         AW           = SAP1_AW,
   parameter int         DW           = SAP1_DW,
   parameter logic [7:0] SYNC_BYTE    = SAP1_SYNC_BYTE
)(
   input  logic                  clk,
   input  logic                  n_clr,
   input  logic                  start,
   sap1_memory_dump_tx_if.master mem,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);
   localparam logic [AW:0] DEPTH_IDX = (AW + 1)'(DEPTH);

   state_t        state, state_next;
   logic [AW:0]   idx;
   logic [AW-1:0] mem_a_q;
   logic          load;
   logic          frame_done;
   logic          rd;
   logic [DW-1:0] byte_in;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      byte_in    = DW'(SYNC_BYTE);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_START;
               load       = 1'b1;
            end
         end
         ST_START: begin
            if (frame_done) state_next = (idx < DEPTH_IDX) ? ST_READ : ST_DONE;
         end
         ST_READ:  state_next = ST_LATCH;
         ST_LATCH: begin
            state_next = ST_START;
            load       = 1'b1;
            byte_in    = mem.mem_d;
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_clr) begin
         state   <= ST_IDLE;
         idx     <= '0;
         mem_a_q <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start) idx <= '0;
         if (state == ST_LATCH) begin
            idx     <= idx + 1'b1;
            mem_a_q <= idx[AW-1:0];
         end
      end
   end

   assign rd           = (state == ST_READ) || (state == ST_LATCH);
   assign mem.mem_a    = rd ? idx[AW-1:0] : mem_a_q;
   assign mem.mem_n_ce = ~rd;
   assign busy         = (state != ST_IDLE) && (state != ST_DONE);
   assign done         = (state == ST_DONE);

   sap1_uart_tx_serializer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .n_clr     (n_clr),
      .load      (load),
      .byte_in   (byte_in),
      .tx        (tx),
      .frame_done(frame_done)
   );
endmodule

// File: tb/tb_sap1_memory_dump_tx.sv
// tb/tb_sap1_memory_dump_tx.sv - directed self-checking bench for sap1_memory_dump_tx
module tb_sap1_memory_dump_tx;
   localparam int CPB  = 4;
   localparam int NMAX = 1500;

   logic clk;
   logic n_clr;
   logic start;
   logic tx;
   logic busy;
   logic done;
   logic [7:0] ram [16];

   int checks;
   int failures;

   logic       tx_s   [NMAX];
   logic       busy_s [NMAX];
   logic       done_s [NMAX];
   logic       ce_s   [NMAX];
   logic [3:0] a_s    [NMAX];
   int         nsamp;

   logic [7:0] bytes_q [$];
   logic [3:0] visit_q [$];
   int         done_first;
   int         done_second;
   int         done_cnt;
   int         ce_cnt;

   sap1_memory_dump_tx_if #(.AW(4), .DW(8)) mif ();

   assign mif.mem_d = mif.mem_n_ce ? 8'hxx : ram[mif.mem_a];

   sap1_memory_dump_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk  (clk),
      .n_clr(n_clr),
      .start(start),
      .mem  (mif),
      .tx   (tx),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample j holds the outputs after edge k+j, where k is the edge that sees start.
   task automatic capture(input int n, input int p1, input int p2, input int rst_at, input int hold_len);
      @(negedge clk);
      start = 1'b1;
      nsamp = n;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         tx_s[j]   = tx;
         busy_s[j] = busy;
         done_s[j] = done;
         ce_s[j]   = mif.mem_n_ce;
         a_s[j]    = mif.mem_a;
         start     = (j < hold_len) || (j == p1) || (j == p2);
         n_clr     = !(j == rst_at);
      end
      start = 1'b0;
      n_clr = 1'b1;
   endtask

   task automatic analyze();
      int j;
      logic [7:0] b;
      bytes_q.delete();
      visit_q.delete();
      done_first  = -1;
      done_second = -1;
      done_cnt    = 0;
      ce_cnt      = 0;
      for (int i = 0; i < nsamp; i++) begin
         if (done_s[i] === 1'b1) begin
            if (done_cnt == 0) done_first = i;
            if (done_cnt == 1) done_second = i;
            done_cnt++;
         end
         if (ce_s[i] === 1'b0) begin
            ce_cnt++;
            if (i == 0 || ce_s[i-1] !== 1'b0) visit_q.push_back(a_s[i]);
         end
      end
      j = 0;
      while (j + 10 * CPB <= nsamp) begin
         if (tx_s[j] === 1'b0) begin
            for (int i = 0; i < 8; i++) b[i] = tx_s[j + CPB * (1 + i) + CPB / 2];
            bytes_q.push_back(b);
            j += 10 * CPB;
         end else begin
            j++;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_clr = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_clr = 1'b0;
      start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx, busy, done, mif.mem_n_ce, mif.mem_a} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'h0}) begin
         failures++;
         $display("FAIL reset_outputs got tx,busy,done,n_ce,a=%b%b%b%b %h want 1001 0", tx, busy, done, mif.mem_n_ce, mif.mem_a);
      end
      start = 1'b0;
      n_clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_dump(input int p1, input int p2);
      logic [7:0] exp_b;
      for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
      capture(730, p1, p2, -1, 0);
      analyze();
      checks++;
      if (busy_s[0] !== 1'b1 || tx_s[0] !== 1'b0) begin
         failures++;
         $display("FAIL first_cycle busy=%b tx=%b want busy=1 tx=0", busy_s[0], tx_s[0]);
      end
      checks++;
      if (bytes_q.size() != 17) begin
         failures++;
         $display("FAIL byte_count got %0d want 17", bytes_q.size());
      end
      for (int i = 0; i < 17 && i < bytes_q.size(); i++) begin
         exp_b = (i == 0) ? 8'hA5 : 8'h0F + 8'(i);
         checks++;
         if (bytes_q[i] !== exp_b) begin
            failures++;
            $display("FAIL byte_%0d got %h want %h", i, bytes_q[i], exp_b);
         end
      end
      checks++;
      if (done_first != 712 || done_cnt != 1) begin
         failures++;
         $display("FAIL done_timing first=%0d count=%0d want 712 and 1", done_first, done_cnt);
      end
      checks++;
      if (ce_cnt != 32) begin
         failures++;
         $display("FAIL n_ce_low_cycles got %0d want 32", ce_cnt);
      end
      checks++;
      if (visit_q.size() != 16) begin
         failures++;
         $display("FAIL addr_visits got %0d want 16", visit_q.size());
      end
      for (int i = 0; i < 16 && i < visit_q.size(); i++) begin
         checks++;
         if (visit_q[i] !== 4'(i)) begin
            failures++;
            $display("FAIL addr_order_%0d got %h want %h", i, visit_q[i], 4'(i));
         end
      end
      do_reset();
   endtask

   task automatic test_bit_timing();
      logic [39:0] obs;
      logic [39:0] exp_w;
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0] = 8'h01;
      exp_w  = {4'b0000, 4'b1111, 28'h0, 4'b1111};
      capture(100, -1, -1, -1, 0);
      for (int i = 0; i < 40; i++) obs[39 - i] = tx_s[42 + i];
      checks++;
      if (obs !== exp_w) begin
         failures++;
         $display("FAIL bit_timing got %h want %h", obs, exp_w);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
      capture(222, -1, -1, 220, 0);
      checks++;
      if ({tx_s[221], busy_s[221], done_s[221], ce_s[221]} !== 4'b1001) begin
         failures++;
         $display("FAIL reset_mid got tx,busy,done,n_ce=%b%b%b%b want 1001", tx_s[221], busy_s[221], done_s[221], ce_s[221]);
      end
      checks++;
      if (tx_s[220] !== 1'b1 && tx_s[220] !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_pre tx=%b want 0 or 1", tx_s[220]);
      end
      capture(730, -1, -1, -1, 0);
      analyze();
      checks++;
      if (bytes_q.size() == 0 || bytes_q[0] !== 8'hA5) begin
         failures++;
         $display("FAIL restart_sync got %h want a5", (bytes_q.size() == 0) ? 8'h00 : bytes_q[0]);
      end
      checks++;
      if (visit_q.size() == 0 || visit_q[0] !== 4'h0) begin
         failures++;
         $display("FAIL restart_addr got %h want 0", (visit_q.size() == 0) ? 4'hf : visit_q[0]);
      end
      checks++;
      if (done_first != 712) begin
         failures++;
         $display("FAIL restart_done got %0d want 712", done_first);
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
      capture(1440, -1, -1, -1, 1420);
      analyze();
      checks++;
      if (done_cnt != 2 || done_first != 712 || done_second != 1426) begin
         failures++;
         $display("FAIL b2b_done count=%0d first=%0d second=%0d want 2 712 1426", done_cnt, done_first, done_second);
      end
      checks++;
      if ({busy_s[713], done_s[713], busy_s[714], tx_s[714]} !== 4'b0010) begin
         failures++;
         $display("FAIL b2b_gap got busy713,done713,busy714,tx714=%b%b%b%b want 0010", busy_s[713], done_s[713], busy_s[714], tx_s[714]);
      end
      checks++;
      if (bytes_q.size() != 34 || bytes_q[17] !== 8'hA5) begin
         failures++;
         $display("FAIL b2b_bytes count=%0d want 34 with a5 at 17", bytes_q.size());
      end
      checks++;
      if (busy_s[1428] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle busy=%b want 0", busy_s[1428]);
      end
      do_reset();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      n_clr    = 1'b0;
      start    = 1'b0;
      test_reset();
      test_full_dump(-1, -1);
      test_bit_timing();
      test_full_dump(50, 300);
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
